// File: rtl/sr595_pkg.sv
// sr595_pkg: shared types and width helpers for the 74HC595 chain driver.
//   state_t : controller FSM states
//   ph_w()  : phase counter width for a given CLK_DIV (never below 1 bit)
//   bc_w()  : bit counter width able to hold the value W
package sr595_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH_HI,
    ST_LATCH_LO,
    ST_CLEAR
  } state_t;

  function automatic int ph_w(input int clk_div);
    int w;
    w = $clog2(clk_div);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int bc_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sr595_phase_tick.sv
// sr595_phase_tick: phase counter that paces every non-idle driver state.
// Counts 0..CLK_DIV-1; tick is high on the last count. restart forces the
// next count back to 0 so each state entry starts a fresh phase.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   restart    : clear the phase on the next edge
//   tick       : phase is at CLK_DIV-1 (constantly high when CLK_DIV=1)
module sr595_phase_tick
  import sr595_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int PH_W = ph_w(CLK_DIV);
  localparam logic [PH_W-1:0] LAST = PH_W'(CLK_DIV - 1);

  logic [PH_W-1:0] phase_q;

  assign tick = (phase_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
    end else if (restart || tick) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + PH_W'(1);
    end
  end

endmodule

// File: rtl/sr595_driver.sv
// sr595_driver: serialises a parallel word into a chain of 74HC595 registers
// (MSB first, divided shift clock), then pulses the storage clock. Also runs
// a master-reset clear sequence and drives output enable.
// Ports:
//   clk, reset              : system clock, synchronous active-high reset
//   data_in/valid/ready     : word handshake (accepted only while idle)
//   clear_req               : clear all outputs, wins over data_valid
//   out_enable              : level, drives oe_n inverted one cycle later
//   busy                    : inverse of data_ready outside reset
//   shcp, stcp, ds, mr_n, oe_n : registered 595 pins
//
// state       | meaning
// ST_IDLE     | ready for a word or a clear request
// ST_SHIFT_LO | shcp low, ds presents the buffer MSB
// ST_SHIFT_HI | shcp high, ds held; shift and count on the last phase
// ST_LATCH_HI | stcp high, transfers the shift register to the outputs
// ST_LATCH_LO | stcp low, trailing half of the storage pulse
// ST_CLEAR    | mr_n low, zeroes the shift register
module sr595_driver
  import sr595_pkg::*;
#(
  parameter int NUM_CHIPS = 1,
  parameter int CLK_DIV   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*NUM_CHIPS-1:0] data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  input  logic                   clear_req,
  input  logic                   out_enable,
  output logic                   busy,
  output logic                   shcp,
  output logic                   stcp,
  output logic                   ds,
  output logic                   mr_n,
  output logic                   oe_n
);

  localparam int W    = 8 * NUM_CHIPS;
  localparam int BC_W = bc_w(W);

  state_t          state_q, state_d;
  logic [W-1:0]    buf_q, buf_d;
  logic [BC_W-1:0] cnt_q, cnt_d;
  logic            tick;
  logic            restart;
  logic            ds_d;

  sr595_phase_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_phase (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    case (state_q)
      // Gate on data_ready: it stays low for the first cycle after reset.
      ST_IDLE: begin
        if (data_ready) begin
          if (clear_req) begin
            state_d = ST_CLEAR;
          end else if (data_valid) begin
            buf_d   = data_in;
            cnt_d   = BC_W'(W);
            state_d = ST_SHIFT_LO;
          end
        end
      end
      ST_SHIFT_LO: if (tick) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (tick) begin
          buf_d   = {buf_q[W-2:0], 1'b0};
          cnt_d   = cnt_q - BC_W'(1);
          state_d = (cnt_q == BC_W'(1)) ? ST_LATCH_HI : ST_SHIFT_LO;
        end
      end
      ST_LATCH_HI: if (tick) state_d = ST_LATCH_LO;
      ST_LATCH_LO: if (tick) state_d = ST_IDLE;
      ST_CLEAR:    if (tick) state_d = ST_LATCH_HI;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign restart = (state_d != state_q);

  // Pins are decoded from the next state so they line up with the state
  // register cycle-for-cycle while still coming straight from flops.
  assign ds_d = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) ? buf_d[W-1] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      shcp       <= 1'b0;
      stcp       <= 1'b0;
      ds         <= 1'b0;
      mr_n       <= 1'b1;
      oe_n       <= 1'b1;
      data_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      shcp       <= (state_d == ST_SHIFT_HI);
      stcp       <= (state_d == ST_LATCH_HI);
      ds         <= ds_d;
      mr_n       <= (state_d != ST_CLEAR);
      oe_n       <= ~out_enable;
      data_ready <= (state_d == ST_IDLE);
      busy       <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_sr595_driver.sv
// Bench for sr595_driver: three instances (1 chip/div 2, 2 chips/div 1,
// 1 chip/div 4) checked every cycle against a timing model built from the
// frame/clear schedule formulas, plus a behavioural 595 chain per instance.
module tb_sr595_driver;

  localparam int CD_A [3] = '{2, 1, 4};
  localparam int W_A  [3] = '{8, 16, 8};

  logic        clk;
  logic        reset;
  logic [15:0] din [3];
  logic [2:0]  dv, cr, oe;
  wire  [2:0]  rdy, bsy, sh, st, dsp, mr, oen;

  int nchk, nerr, cyc;

  // schedule model
  bit          rst_edge;
  bit          act [3];
  bit          clr [3];
  int          t0 [3];
  logic [15:0] wrd [3];
  bit          oe_exp [3];
  int          nhs [3], hs_cyc [3], nclr [3], clr_cyc [3];

  // external 595 chain model
  logic [15:0] sreg [3], q [3], dsbits [3];
  bit          sh_p [3], st_p [3];
  int          nsh [3], nst [3], nmrlo [3], nsthi [3];

  sr595_driver #(.NUM_CHIPS(1), .CLK_DIV(2)) u0 (
    .clk(clk), .reset(reset), .data_in(din[0][7:0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .clear_req(cr[0]), .out_enable(oe[0]), .busy(bsy[0]),
    .shcp(sh[0]), .stcp(st[0]), .ds(dsp[0]), .mr_n(mr[0]), .oe_n(oen[0]));

  sr595_driver #(.NUM_CHIPS(2), .CLK_DIV(1)) u1 (
    .clk(clk), .reset(reset), .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .clear_req(cr[1]), .out_enable(oe[1]), .busy(bsy[1]),
    .shcp(sh[1]), .stcp(st[1]), .ds(dsp[1]), .mr_n(mr[1]), .oe_n(oen[1]));

  sr595_driver #(.NUM_CHIPS(1), .CLK_DIV(4)) u2 (
    .clk(clk), .reset(reset), .data_in(din[2][7:0]), .data_valid(dv[2]),
    .data_ready(rdy[2]), .clear_req(cr[2]), .out_enable(oe[2]), .busy(bsy[2]),
    .shcp(sh[2]), .stcp(st[2]), .ds(dsp[2]), .mr_n(mr[2]), .oe_n(oen[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h expected=%0h cycle=%0d", nm, got, exp, cyc);
    end
  endtask

  // Accept decisions use the inputs present at the edge and the model's own
  // notion of readiness for the cycle that is ending.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int len;
      bit rdy_e;
      len   = clr[i] ? 3 * CD_A[i] : 2 * (W_A[i] + 1) * CD_A[i];
      rdy_e = !rst_edge && !(act[i] && (cyc - t0[i]) <= len);
      if (reset) begin
        act[i] = 1'b0;
      end else if (rdy_e && cr[i]) begin
        act[i] = 1'b1; clr[i] = 1'b1; t0[i] = cyc;
        nclr[i]++; clr_cyc[i] = cyc;
      end else if (rdy_e && dv[i]) begin
        act[i] = 1'b1; clr[i] = 1'b0; t0[i] = cyc; wrd[i] = din[i];
        nhs[i]++; hs_cyc[i] = cyc;
      end
      oe_exp[i] = reset ? 1'b1 : !oe[i];
    end
    rst_edge = reset;
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int i = 0; i < 3; i++) begin
        int cd, w, d, len;
        bit e_rdy, e_sh, e_st, e_mr, e_ds, ds_chk;
        cd = CD_A[i]; w = W_A[i]; d = cyc - t0[i];
        len = clr[i] ? 3 * cd : 2 * (w + 1) * cd;
        e_sh = 1'b0; e_st = 1'b0; e_mr = 1'b1; e_ds = 1'b0; ds_chk = 1'b1;
        e_rdy = !rst_edge && !(act[i] && d <= len);
        if (!rst_edge && act[i] && d >= 1 && d <= len) begin
          if (clr[i]) begin
            e_mr = (d > cd);
            e_st = (d > cd) && (d <= 2 * cd);
          end else if (d <= 2 * w * cd) begin
            e_sh = (((d - 1) / cd) % 2) == 1;
            e_ds = wrd[i][w - 1 - (d - 1) / (2 * cd)];
          end else begin
            e_st   = (d <= (2 * w + 1) * cd);
            ds_chk = !e_st;
          end
        end
        chk($sformatf("u%0d data_ready", i), rdy[i], e_rdy);
        chk($sformatf("u%0d busy", i), bsy[i], rst_edge ? 1'b0 : !e_rdy);
        chk($sformatf("u%0d shcp", i), sh[i], e_sh);
        chk($sformatf("u%0d stcp", i), st[i], e_st);
        chk($sformatf("u%0d mr_n", i), mr[i], e_mr);
        chk($sformatf("u%0d oe_n", i), oen[i], oe_exp[i]);
        if (ds_chk) chk($sformatf("u%0d ds", i), dsp[i], e_ds);

        if (sh[i] && !sh_p[i]) begin
          sreg[i]   = {sreg[i][14:0], dsp[i]};
          dsbits[i] = {dsbits[i][14:0], dsp[i]};
          nsh[i]++;
        end
        if (!mr[i]) begin
          sreg[i] = '0;
          nmrlo[i]++;
        end
        if (st[i]) nsthi[i]++;
        if (st[i] && !st_p[i]) begin
          q[i] = (w == 8) ? (sreg[i] & 16'h00FF) : sreg[i];
          nst[i]++;
        end
        sh_p[i] = sh[i];
        st_p[i] = st[i];
      end
    end
  end

  task automatic wait_hs(input int i, input int h, input string nm);
    int k;
    k = 0;
    while (nhs[i] == h && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(nm, nhs[i] - h, 1);
  endtask

  task automatic send(input int i, input logic [15:0] word);
    int h;
    h = nhs[i];
    din[i] = word;
    dv[i]  = 1'b1;
    wait_hs(i, h, $sformatf("u%0d handshake", i));
    dv[i] = 1'b0;
  endtask

  task automatic wait_ready(input int i, output int at);
    int k;
    k = 0;
    while (rdy[i] !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("u%0d ready wait", i), rdy[i], 1'b1);
    at = cyc;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", nerr, nchk);
    $fatal(1);
  end

  initial begin
    int t, t2, at, h;
    nchk = 0; nerr = 0; cyc = 0; rst_edge = 1'b0;
    reset = 1'b1; dv = '0; cr = '0; oe = '0;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; act[i] = 1'b0; clr[i] = 1'b0; t0[i] = 0; wrd[i] = '0;
      oe_exp[i] = 1'b1; nhs[i] = 0; hs_cyc[i] = 0; nclr[i] = 0; clr_cyc[i] = 0;
      sreg[i] = '0; q[i] = '0; dsbits[i] = '0; sh_p[i] = 1'b0; st_p[i] = 1'b0;
      nsh[i] = 0; nst[i] = 0; nmrlo[i] = 0; nsthi[i] = 0;
    end

    // reset values, ready one cycle after release
    repeat (3) @(negedge clk);
    chk("reset pins u0", {sh[0], st[0], dsp[0], mr[0], oen[0], rdy[0], bsy[0]}, 7'b0001100);
    chk("reset pins u2", {sh[2], st[2], dsp[2], mr[2], oen[2], rdy[2], bsy[2]}, 7'b0001100);
    reset = 1'b0;
    @(negedge clk);
    chk("ready after reset", rdy, 3'b111);

    // 0xA5, one chip, CLK_DIV=2
    dsbits[0] = '0; nsh[0] = 0;
    send(0, 16'h00A5);
    t = hs_cyc[0];
    wait_ready(0, at);
    chk("A5 ready latency", at - t, 37);
    chk("A5 ds at shcp rises", dsbits[0][7:0], 8'hA5);
    chk("A5 shcp count", nsh[0], 8);
    chk("A5 outputs", q[0], 16'h00A5);

    // 0x8001, two chips, CLK_DIV=1, out_enable toggled mid-frame
    nsh[1] = 0; nst[1] = 0;
    send(1, 16'h8001);
    t = hs_cyc[1];
    oe[1] = 1'b1;
    @(negedge clk);
    chk("oe_n follows high enable", oen[1], 1'b0);
    oe[1] = 1'b0;
    @(negedge clk);
    chk("oe_n follows low enable", oen[1], 1'b1);
    wait_ready(1, at);
    chk("8001 ready latency", at - t, 35);
    chk("8001 shcp count", nsh[1], 16);
    chk("8001 stcp count", nst[1], 1);
    chk("8001 outputs", q[1], 16'h8001);

    // clear wins over data_valid, CLK_DIV=4
    send(2, 16'h00FF);
    wait_ready(2, at);
    chk("FF outputs", q[2], 16'h00FF);
    nmrlo[2] = 0; nsthi[2] = 0;
    h = nclr[2];
    din[2] = 16'h005A; dv[2] = 1'b1; cr[2] = 1'b1;
    @(negedge clk);
    chk("clear accepted", nclr[2] - h, 1);
    cr[2] = 1'b0;
    wait_hs(2, nhs[2], "u2 data after clear");
    dv[2] = 1'b0;
    chk("data accepted first idle after clear", hs_cyc[2] - clr_cyc[2], 13);
    chk("clear mr_n low cycles", nmrlo[2], 4);
    chk("clear stcp high cycles", nsthi[2], 4);
    chk("outputs after clear", q[2], 16'h0000);
    wait_ready(2, at);
    chk("5A outputs after clear", q[2], 16'h005A);

    // reset during a 0x3C frame
    send(0, 16'h003C);
    t = hs_cyc[0];
    while (cyc < t + 10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort pins u0", {sh[0], st[0], dsp[0], mr[0], oen[0], rdy[0], bsy[0]}, 7'b0001100);
    nst[0] = 0;
    reset = 1'b0;
    @(negedge clk);
    chk("ready after abort", rdy[0], 1'b1);
    repeat (40) @(negedge clk);
    chk("no stcp after abort", nst[0], 0);
    chk("outputs kept after abort", q[0], 16'h00A5);

    // held valid with data_in changing mid-frame
    dsbits[0] = '0;
    h = nhs[0];
    din[0] = 16'h0011; dv[0] = 1'b1;
    wait_hs(0, h, "u0 first held word");
    t = hs_cyc[0];
    repeat (5) @(negedge clk);
    din[0] = 16'h0022;
    wait_hs(0, nhs[0], "u0 second held word");
    dv[0] = 1'b0;
    t2 = hs_cyc[0];
    chk("back-to-back gap", t2 - t, 37);
    chk("first frame bits", dsbits[0][7:0], 8'h11);
    chk("first frame outputs", q[0], 16'h0011);
    wait_ready(0, at);
    chk("second frame outputs", q[0], 16'h0022);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
